// File: rtl/data_store_pkg.sv
// Shared constants for the processor/main-memory controller port: address
// width, main-memory prefix, command codes and single-word burst length.
package data_store_pkg;

  localparam int ADDR_BITS     = 16;
  localparam int CMD_ADDR_BITS = 30;

  localparam logic [CMD_ADDR_BITS-ADDR_BITS-1:0] MAIN_MEM_PREFIX = 14'h0800;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [5:0] BL_SINGLE = 6'b000000;

endpackage

// File: rtl/data_store.sv
// Store path: one 16-bit store becomes a data-FIFO push then a single-word write command.
// Optional sticky FIFO error flag is compiled in with DATA_STORE_ERR_CHECK_EN.
module data_store #(
  parameter int ADDR_BITS  = data_store_pkg::ADDR_BITS,
  parameter int DATA_BITS  = 16,
  parameter bit WAIT_DRAIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_done,
  input  logic                 st_req,
  input  logic [ADDR_BITS-1:0] st_addr,
  input  logic [DATA_BITS-1:0] st_data,
  output logic                 ready,
  output logic                 mem_cmd_en,
  output logic [2:0]           mem_cmd_instr,
  output logic [5:0]           mem_cmd_bl,
  output logic [29:0]          mem_cmd_byte_addr,
  input  logic                 mem_cmd_empty,
  input  logic                 mem_cmd_full,
  output logic                 mem_wr_en,
  output logic [3:0]           mem_wr_mask,
  output logic [31:0]          mem_wr_data,
  input  logic                 mem_wr_full,
  input  logic                 mem_wr_empty,
  input  logic [6:0]           mem_wr_count,
  input  logic                 mem_wr_underrun,
  input  logic                 mem_wr_error,
  output logic                 err
);

  typedef enum logic [2:0] {PRE_BOOT, IDLE, DATA, CMD, DRAIN} state_t;

  state_t                 state_r, state_s;
  logic [ADDR_BITS-1:1]   addr_r, addr_s;
  logic [DATA_BITS-1:0]   data_r, data_s;
  logic                   ready_r, ready_s;
  logic                   cmd_en_r, cmd_en_s;
  logic                   wr_en_r, wr_en_s;
  logic [3:0]             wr_mask_r, wr_mask_s;
  logic [31:0]            wr_data_r, wr_data_s;
  logic [29:0]            cmd_addr_r, cmd_addr_s;
  logic [35:0]            lane_s;

  // Big-endian halfword placement: addr[1]=0 is the upper lane; mask bit 1 = byte kept.
  function automatic logic [35:0] place_lane(input logic lo_lane, input logic [DATA_BITS-1:0] d);
    logic [35:0] r;
    if (lo_lane) begin
      r = {4'b1100, 16'h0000, d};
    end else begin
      r = {4'b0011, d, 16'h0000};
    end
    return r;
  endfunction

  assign lane_s        = place_lane(addr_r[1], data_r);
  assign mem_cmd_instr = data_store_pkg::CMD_WRITE;
  assign mem_cmd_bl    = data_store_pkg::BL_SINGLE;

  // Next-state and next-output logic; ready only rises one edge after IDLE is entered.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    data_s     = data_r;
    ready_s    = 1'b0;
    cmd_en_s   = 1'b0;
    wr_en_s    = 1'b0;
    wr_mask_s  = wr_mask_r;
    wr_data_s  = wr_data_r;
    cmd_addr_s = cmd_addr_r;
    case (state_r)
      PRE_BOOT: begin
        if (boot_done) begin
          state_s = IDLE;
        end else begin
          state_s = PRE_BOOT;
        end
      end
      IDLE: begin
        if (st_req && ready_r) begin
          addr_s  = st_addr[ADDR_BITS-1:1];
          data_s  = st_data;
          state_s = DATA;
        end else begin
          ready_s = 1'b1;
        end
      end
      DATA: begin
        if (!mem_wr_full) begin
          wr_en_s   = 1'b1;
          wr_mask_s = lane_s[35:32];
          wr_data_s = lane_s[31:0];
          state_s   = CMD;
        end else begin
          state_s = DATA;
        end
      end
      CMD: begin
        if (!mem_cmd_full) begin
          cmd_en_s   = 1'b1;
          cmd_addr_s = {data_store_pkg::MAIN_MEM_PREFIX, addr_r[ADDR_BITS-1:2], 2'b00};
          if (WAIT_DRAIN) begin
            state_s = DRAIN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = CMD;
        end
      end
      DRAIN: begin
        if (mem_wr_empty && mem_cmd_empty) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = PRE_BOOT;
      end
    endcase
  end

  // State, captured store and registered controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= PRE_BOOT;
      addr_r     <= '0;
      data_r     <= '0;
      ready_r    <= 1'b0;
      cmd_en_r   <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_mask_r  <= 4'hF;
      wr_data_r  <= 32'h0000_0000;
      cmd_addr_r <= 30'h0000_0000;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      ready_r    <= ready_s;
      cmd_en_r   <= cmd_en_s;
      wr_en_r    <= wr_en_s;
      wr_mask_r  <= wr_mask_s;
      wr_data_r  <= wr_data_s;
      cmd_addr_r <= cmd_addr_s;
    end
  end

  assign ready             = ready_r;
  assign mem_cmd_en        = cmd_en_r;
  assign mem_wr_en         = wr_en_r;
  assign mem_wr_mask       = wr_mask_r;
  assign mem_wr_data       = wr_data_r;
  assign mem_cmd_byte_addr = cmd_addr_r;

`ifdef DATA_STORE_ERR_CHECK_EN
  logic err_r;
  logic unused_s;

  // Sticky FIFO fault flag; 64 is the write-FIFO depth, so a larger count is corrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | mem_wr_underrun | mem_wr_error | (mem_wr_count > 7'd64);
    end
  end

  assign err      = err_r;
  assign unused_s = st_addr[0];
`else
  logic unused_s;

  assign err      = 1'b0;
  assign unused_s = ^{st_addr[0], mem_wr_count, mem_wr_underrun, mem_wr_error};
`endif

endmodule

// File: tb/tb_data_store.sv
// Directed bench for data_store with a scoreboard of expected data pushes and commands.
module tb_data_store;

  localparam logic [13:0] PREFIX = 14'h0800;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_done = 1'b0;
  logic        st_req = 1'b0;
  logic [15:0] st_addr = 16'h0000;
  logic [15:0] st_data = 16'h0000;
  logic        ready;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_empty = 1'b1;
  logic        mem_cmd_full = 1'b0;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic        mem_wr_full = 1'b0;
  logic        mem_wr_empty = 1'b1;
  logic [6:0]  mem_wr_count = 7'd0;
  logic        mem_wr_underrun = 1'b0;
  logic        mem_wr_error = 1'b0;
  logic        err;

  wexp_t       wq[$];
  logic [29:0] cq[$];
  int cyc = 0;
  int wr_cnt = 0, cmd_cnt = 0, wr_cyc = -1, cmd_cyc = -1, acc_cyc = 0;
  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

  data_store dut (
    .clk(clk), .rst_n(rst_n), .boot_done(boot_done), .st_req(st_req),
    .st_addr(st_addr), .st_data(st_data), .ready(ready),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_empty(mem_cmd_empty),
    .mem_cmd_full(mem_cmd_full), .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask),
    .mem_wr_data(mem_wr_data), .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty),
    .mem_wr_count(mem_wr_count), .mem_wr_underrun(mem_wr_underrun),
    .mem_wr_error(mem_wr_error), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_cmd_en"}, mem_cmd_en, 1'b0);
    check({tag, "_wr_en"}, mem_wr_en, 1'b0);
    check({tag, "_mask"}, mem_wr_mask, 4'hF);
    check({tag, "_data"}, mem_wr_data, 32'h0);
    check({tag, "_addr"}, mem_cmd_byte_addr, 30'h0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // Scoreboard: each strobe pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en) begin
        wexp_t e;
        wr_cnt++;
        wr_cyc = cyc;
        check("wr_excl_cmd", mem_cmd_en, 1'b0);
        if (wq.size() == 0) begin
          check("wr_unexpected", 1'b1, 1'b0);
        end else begin
          e = wq.pop_front();
          check("wr_data", mem_wr_data, e.data);
          check("wr_mask", mem_wr_mask, e.mask);
        end
      end
      if (mem_cmd_en) begin
        cmd_cnt++;
        cmd_cyc = cyc;
        check("cmd_instr", mem_cmd_instr, 3'b000);
        check("cmd_bl", mem_cmd_bl, 6'b000000);
        check("cmd_after_wr", (cmd_cyc > wr_cyc), 1'b1);
        if (cq.size() == 0) begin
          check("cmd_unexpected", 1'b1, 1'b0);
        end else begin
          check("cmd_addr", mem_cmd_byte_addr, cq.pop_front());
        end
      end
    end
  end

  task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                          input logic [31:0] exp_data, input logic [3:0] exp_mask,
                          input logic [13:0] exp_word);
    int n = 0;
    wexp_t e;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1'b1);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    e.data = exp_data;
    e.mask = exp_mask;
    wq.push_back(e);
    cq.push_back({PREFIX, exp_word, 2'b00});
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    st_req  = 1'b0;
    check("ready_drop", ready, 1'b0);
  endtask

  task automatic wait_cmd(input int c0, input string tag);
    int n = 0;
    while (cmd_cnt <= c0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, (cmd_cnt > c0), 1'b1);
  endtask

  initial begin
    int  w0, c0;
    bit  seen;

    repeat (3) @(negedge clk);
    check_reset("rst");
    check("rst_instr", mem_cmd_instr, 3'b000);
    check("rst_bl", mem_cmd_bl, 6'b000000);

    // Boot gate: requests refused until boot_done
    rst_n   = 1'b1;
    st_req  = 1'b1;
    st_addr = 16'h0002;
    st_data = 16'hDEAD;
    seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    check("boot_ready_low", seen, 1'b0);
    check("boot_no_wr", wr_cnt, 0);
    st_req    = 1'b0;
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    @(negedge clk);
    check("boot_ready_up", ready, 1'b1);
    repeat (2) @(negedge clk);
    check("boot_sticky", ready, 1'b1);

    // Low-half store with exact latency
    do_store(16'h1236, 16'hBEEF, 32'h0000BEEF, 4'b1100, 14'h048D);
    repeat (4) @(negedge clk);
    check("lat_ready_t3", ready, 1'b0);
    @(negedge clk);
    check("lat_ready_t4", ready, 1'b1);
    check("lat_wr", wr_cyc, acc_cyc + 1);
    check("lat_cmd", cmd_cyc, acc_cyc + 2);

    // High-half store
    do_store(16'h0010, 16'h1234, 32'h12340000, 4'b0011, 14'h0004);
    repeat (5) @(negedge clk);
    check("hi_cmd_gap", cmd_cyc - wr_cyc, 1);

    // Backpressure on both FIFOs
    mem_wr_full = 1'b1;
    w0 = wr_cnt;
    c0 = cmd_cnt;
    do_store(16'hABCE, 16'h5A5A, 32'h00005A5A, 4'b1100, 14'h2AF3);
    repeat (5) @(negedge clk);
    check("bp_wr_stall", wr_cnt, w0);
    mem_wr_full  = 1'b0;
    mem_cmd_full = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_wr_once", wr_cnt, w0 + 1);
    check("bp_cmd_stall", cmd_cnt, c0);
    mem_cmd_full = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_cmd_once", cmd_cnt, c0 + 1);
    check("bp_wr_still_once", wr_cnt, w0 + 1);

    // Drain wait, then back-to-back store
    mem_wr_empty = 1'b0;
    c0 = cmd_cnt;
    do_store(16'h4000, 16'hC0DE, 32'hC0DE0000, 4'b0011, 14'h1000);
    wait_cmd(c0, "drain_cmd_seen");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    check("drain_ready_held", seen, 1'b0);
    mem_wr_empty = 1'b1;
    c0 = cmd_cnt;
    do_store(16'hFFFE, 16'h0102, 32'h00000102, 4'b1100, 14'h3FFF);
    wait_cmd(c0, "b2b_cmd_seen");

    // Reset while stalled in CMD
    mem_cmd_full = 1'b1;
    w0 = wr_cnt;
    do_store(16'h2222, 16'h7777, 32'h00007777, 4'b1100, 14'h0888);
    repeat (3) @(negedge clk);
    check("midrst_wr_done", wr_cnt, w0 + 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    check("midrst_wq_empty", wq.size(), 0);
    cq.delete();
    mem_cmd_full = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    c0 = cmd_cnt;
    do_store(16'h0008, 16'hA5A5, 32'hA5A50000, 4'b0011, 14'h0002);
    wait_cmd(c0, "post_rst_cmd_seen");

    // Error flag
    @(negedge clk);
    mem_wr_error = 1'b1;
    @(negedge clk);
    mem_wr_error = 1'b0;
`ifdef DATA_STORE_ERR_CHECK_EN
    check("err_set", err, 1'b1);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("err_cleared", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("err_tied", err, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("wq_drained", wq.size(), 0);
    check("cq_drained", cq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
